// File: rtl/lane_serializer_pkg.sv
// Shared types and width helpers for the lane serializer and its link-side checker.
package lane_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

  localparam int GAP_CNT_W = 8;

  // Smallest r with 2^r >= data_width + r + 1.
  function automatic int hamming_parity_bits(input int data_width);
    int r;
    r = 0;
    while ((1 << r) < data_width + r + 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/lane_serializer_hamming_parity_calc.sv
// Combinational Hamming parity generator: parity bits at power-of-two codeword
// positions, data bits filling the remaining positions in ascending order.
module hamming_parity_calc
  import lane_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]                          data_i,
  output logic [hamming_parity_bits(DATA_WIDTH)-1:0]     parity_o
);

  localparam int P          = hamming_parity_bits(DATA_WIDTH);
  localparam int FRAME_BITS = DATA_WIDTH + P;

  // Data bits covered by parity bit bit_i; resolved at elaboration time.
  function automatic logic [DATA_WIDTH-1:0] parity_mask(input int bit_i);
    logic [DATA_WIDTH-1:0] m;
    int idx;
    m   = '0;
    idx = 0;
    for (int pos = 1; pos <= FRAME_BITS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> bit_i) & 1) != 0) m = m | (DATA_WIDTH'(1) << idx);
        idx++;
      end
    end
    return m;
  endfunction

  for (genvar i = 0; i < P; i++) begin : g_parity
    assign parity_o[i] = ^(data_i & parity_mask(i));
  end

endmodule

// File: rtl/lane_serializer.sv
// Multi-lane serializer: accepts a word, optionally appends Hamming parity and
// shifts the frame out NUM_LANES bits per beat with start/last/enable qualifiers.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 1,
  parameter int HAS_ECC    = 0,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_GAP   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  output logic [NUM_LANES-1:0]  serial_o,
  output logic                  enable_o,
  output logic                  start_o,
  output logic                  last_o
);

  localparam int P          = (HAS_ECC != 0) ? hamming_parity_bits(DATA_WIDTH) : 0;
  localparam int FRAME_BITS = DATA_WIDTH + P;
  localparam int BEATS      = (FRAME_BITS + NUM_LANES - 1) / NUM_LANES;
  localparam int FV_W       = BEATS * NUM_LANES;
  localparam int PAD        = FV_W - FRAME_BITS;
  localparam int CNT_W      = $clog2(BEATS + 1);

  // The idle cycle before a re-accept is itself one gap cycle, so GAP only
  // has to cover the remaining IDLE_GAP-1 cycles.
  localparam logic [GAP_CNT_W-1:0] GAP_INIT =
    (IDLE_GAP > 1) ? GAP_CNT_W'(IDLE_GAP - 2) : '0;

  logic [FRAME_BITS-1:0] frame_bits;
  logic [FV_W-1:0]       frame_pad;
  logic [FV_W-1:0]       frame_ord;

  if (HAS_ECC != 0) begin : g_ecc
    logic [P-1:0] parity;
    hamming_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data_i   (data_i),
      .parity_o (parity)
    );
    assign frame_bits = {data_i, parity};
  end else begin : g_no_ecc
    assign frame_bits = data_i;
  end

  assign frame_pad = FV_W'(frame_bits) << PAD;

  for (genvar i = 0; i < FV_W; i++) begin : g_order
    assign frame_ord[i] = (MSB_FIRST != 0) ? frame_pad[i] : frame_pad[FV_W-1-i];
  end

  ser_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic [FV_W-1:0]        sreg_q, sreg_d;
  logic [NUM_LANES-1:0]   serial_q, serial_d;
  logic                   enable_q, enable_d;
  logic                   start_q, start_d;
  logic                   last_q, last_d;
  logic                   accept;

  assign ready_o = !flush_i &&
                   (state_q == IDLE || (state_q == SHIFT && last_q && IDLE_GAP == 0));
  assign accept  = valid_i && ready_o;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sreg_d   = sreg_q;
    serial_d = '0;
    enable_d = 1'b0;
    start_d  = 1'b0;
    last_d   = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      gap_d   = '0;
      sreg_d  = '0;
    end else if (accept) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      serial_d = frame_ord[FV_W-1 -: NUM_LANES];
      sreg_d   = frame_ord << NUM_LANES;
      enable_d = 1'b1;
      start_d  = 1'b1;
      last_d   = (BEATS == 1);
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          if (!last_q) begin
            cnt_d    = cnt_q + CNT_W'(1);
            serial_d = sreg_q[FV_W-1 -: NUM_LANES];
            sreg_d   = sreg_q << NUM_LANES;
            enable_d = 1'b1;
            last_d   = (cnt_q + CNT_W'(1)) == CNT_W'(BEATS - 1);
          end else if (IDLE_GAP > 1) begin
            state_d = GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (gap_q == '0) state_d = IDLE;
          else             gap_d   = gap_q - GAP_CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      sreg_q   <= '0;
      serial_q <= '0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sreg_q   <= sreg_d;
      serial_q <= serial_d;
      enable_q <= enable_d;
      start_q  <= start_d;
      last_q   <= last_d;
    end
  end

  assign serial_o = serial_q;
  assign enable_o = enable_q;
  assign start_o  = start_q;
  assign last_o   = last_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench: five serializer configurations driven against a
// bit-list reference model of the frame format.
module tb_lane_serializer;

  localparam int N = 5;

  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  logic [7:0] data  [N];
  logic       valid [N];
  logic       flush [N];
  logic       ready [N];
  logic       en    [N];
  logic       st    [N];
  logic       ls    [N];
  logic [4:0] ser   [N];

  logic       s0;
  logic       s1;
  logic [3:0] s2;
  logic [4:0] s3;
  logic       s4;

  always_comb begin
    ser[0] = {4'b0, s0};
    ser[1] = {4'b0, s1};
    ser[2] = {1'b0, s2};
    ser[3] = s3;
    ser[4] = {4'b0, s4};
  end

  lane_serializer #(.DATA_WIDTH(8), .NUM_LANES(1), .HAS_ECC(0), .MSB_FIRST(1), .IDLE_GAP(0)) u0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .flush_i(flush[0]), .serial_o(s0), .enable_o(en[0]), .start_o(st[0]), .last_o(ls[0]));
  lane_serializer #(.DATA_WIDTH(8), .NUM_LANES(1), .HAS_ECC(1), .MSB_FIRST(1), .IDLE_GAP(2)) u1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .flush_i(flush[1]), .serial_o(s1), .enable_o(en[1]), .start_o(st[1]), .last_o(ls[1]));
  lane_serializer #(.DATA_WIDTH(8), .NUM_LANES(4), .HAS_ECC(1), .MSB_FIRST(1), .IDLE_GAP(0)) u2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data[2]), .valid_i(valid[2]), .ready_o(ready[2]),
    .flush_i(flush[2]), .serial_o(s2), .enable_o(en[2]), .start_o(st[2]), .last_o(ls[2]));
  lane_serializer #(.DATA_WIDTH(8), .NUM_LANES(5), .HAS_ECC(0), .MSB_FIRST(1), .IDLE_GAP(0)) u3 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data[3]), .valid_i(valid[3]), .ready_o(ready[3]),
    .flush_i(flush[3]), .serial_o(s3), .enable_o(en[3]), .start_o(st[3]), .last_o(ls[3]));
  lane_serializer #(.DATA_WIDTH(8), .NUM_LANES(1), .HAS_ECC(0), .MSB_FIRST(0), .IDLE_GAP(1)) u4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data[4]), .valid_i(valid[4]), .ready_o(ready[4]),
    .flush_i(flush[4]), .serial_o(s4), .enable_o(en[4]), .start_o(st[4]), .last_o(ls[4]));

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];

  function automatic int cfg_lanes(input int k);
    if (k == 2) return 4;
    if (k == 3) return 5;
    return 1;
  endfunction

  function automatic int cfg_ecc(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_msb(input int k);
    return (k == 4) ? 0 : 1;
  endfunction

  function automatic int cfg_gap(input int k);
    if (k == 1) return 2;
    if (k == 4) return 1;
    return 0;
  endfunction

  // Packed observation: {ready, enable, start, last, serial[4:0]}.
  function automatic logic [8:0] obs(input int k);
    return {ready[k], en[k], st[k], ls[k], ser[k]};
  endfunction

  // Reference frame: list of bits in transmission order, then grouped into beats.
  task automatic push_frame(input int k, input int d);
    int bits [$];
    int ord  [$];
    int lanes, r, p, di, nb, v, e;
    lanes = cfg_lanes(k);
    for (int b = 7; b >= 0; b--) bits.push_back((d >> b) & 1);
    if (cfg_ecc(k) != 0) begin
      r = 0;
      while ((1 << r) < 8 + r + 1) r++;
      // The parity vector equals the XOR of the codeword positions holding a 1.
      p  = 0;
      di = 0;
      for (int pos = 1; pos <= 8 + r; pos++) begin
        if ((pos & (pos - 1)) != 0) begin
          if (((d >> di) & 1) != 0) p = p ^ pos;
          di++;
        end
      end
      for (int i = r - 1; i >= 0; i--) bits.push_back((p >> i) & 1);
    end
    while ((bits.size() % lanes) != 0) bits.push_back(0);
    if (cfg_msb(k) != 0) ord = bits;
    else for (int i = bits.size() - 1; i >= 0; i--) ord.push_back(bits[i]);
    nb = ord.size() / lanes;
    for (int b = 0; b < nb; b++) begin
      v = 0;
      for (int l = 0; l < lanes; l++) v = v | (ord[b * lanes + l] << (lanes - 1 - l));
      e = v | (1 << 7);
      if (b == 0) e = e | (1 << 6);
      if (b == nb - 1) begin
        e = e | (1 << 5);
        if (cfg_gap(k) == 0) e = e | (1 << 8);
      end
      exp_q.push_back(9'(e));
    end
  endtask

  // Low cycles between/after frames; only the last one is idle and ready.
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i == n - 1) ? 9'h100 : 9'h000);
  endtask

  task automatic run_frames(input int k, input logic [7:0] d0, input logic [7:0] d1,
                            input int nwords, input string name);
    int acc, idx, cyc;
    logic accepted;
    exp_q.delete();
    push_frame(k, int'(d0));
    if (nwords == 2) begin
      push_idle(cfg_gap(k));
      push_frame(k, int'(d1));
    end
    push_idle((cfg_gap(k) > 1) ? cfg_gap(k) : 1);
    valid[k] = 1'b1;
    data[k]  = d0;
    acc = 0;
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      accepted = valid[k] && ready[k];
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      if (accepted) begin
        acc++;
        if (acc < nwords) data[k] = d1;
        else              valid[k] = 1'b0;
      end
      if (acc > 0) begin
        checks++;
        if (obs(k) !== exp_q[idx]) begin
          errors++;
          $display("FAIL %s inst%0d step%0d: rdy/en/st/ls/ser got %b required %b",
                   name, k, idx, obs(k), exp_q[idx]);
        end
        idx++;
      end
    end
    valid[k] = 1'b0;
    if (idx < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s inst%0d timeout: observed %0d of %0d cycles", name, k, idx, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #12;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs(k) !== 9'h100) begin
        errors++;
        $display("FAIL reset inst%0d: got %b required %b", k, obs(k), 9'h100);
      end
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    run_frames(0, 8'hA5, 8'h00, 1, "plain_a5");
    run_frames(1, 8'hA5, 8'h00, 1, "ecc_a5");
    run_frames(2, 8'hA5, 8'h00, 1, "ecc_4lane_a5");
    run_frames(3, 8'hA5, 8'h00, 1, "lane5_a5");
    run_frames(4, 8'h0F, 8'h00, 1, "lsb_first_0f");
  endtask

  task automatic test_back_to_back();
    run_frames(0, 8'hA5, 8'h3C, 2, "b2b_gap0");
    run_frames(1, 8'hA5, 8'h3C, 2, "b2b_gap2");
    run_frames(4, 8'hA5, 8'h3C, 2, "b2b_gap1");
    run_frames(2, 8'h5A, 8'hC3, 2, "b2b_4lane");
  endtask

  task automatic test_random();
    logic [7:0] d0, d1;
    int k;
    for (int i = 0; i < 12; i++) begin
      k  = int'($urandom_range(0, N - 1));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      run_frames(k, d0, d1, int'($urandom_range(1, 2)), "random");
    end
  endtask

  task automatic test_flush(input int k, input int beat, input string name);
    valid[k] = 1'b1;
    data[k]  = 8'($urandom);
    @(posedge clk_i);
    @(negedge clk_i);
    valid[k] = 1'b0;
    repeat (beat) @(negedge clk_i);
    flush[k] = 1'b1;
    valid[k] = 1'b1;
    data[k]  = 8'h77;
    #1;
    checks++;
    if (ready[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_during_flush: got %b required 0", name, ready[k]);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    flush[k] = 1'b0;
    valid[k] = 1'b0;
    #1;
    checks++;
    if (obs(k) !== 9'h100) begin
      errors++;
      $display("FAIL %s after_flush: got %b required %b", name, obs(k), 9'h100);
    end
    @(negedge clk_i);
    checks++;
    if (obs(k) !== 9'h100) begin
      errors++;
      $display("FAIL %s no_resume: got %b required %b", name, obs(k), 9'h100);
    end
    run_frames(k, 8'h96, 8'h00, 1, "post_flush");
  endtask

  task automatic test_async_reset(input int k);
    valid[k] = 1'b1;
    data[k]  = 8'hFF;
    @(posedge clk_i);
    @(negedge clk_i);
    valid[k] = 1'b0;
    repeat (2) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (obs(k) !== 9'h100) begin
      errors++;
      $display("FAIL async_reset inst%0d: got %b required %b", k, obs(k), 9'h100);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs(k) !== 9'h100) begin
      errors++;
      $display("FAIL reset_drop inst%0d: got %b required %b", k, obs(k), 9'h100);
    end
    run_frames(k, 8'h81, 8'h00, 1, "post_reset");
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      data[k]  = 8'h00;
      valid[k] = 1'b0;
      flush[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush(0, 3, "flush_beat3");
    test_flush(1, 11, "flush_last_beat");
    test_flush(2, 1, "flush_4lane");
    test_async_reset(0);
    test_async_reset(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
